// File: rtl/mont_exp.sv
// mont_exp: modular-exponentiation controller (x^e mod m) using left-to-right
// square-and-multiply on one external Montgomery multiplier.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   start       one-cycle request, accepted only in IDLE or DONE
//   in_x        base in Montgomery form (x*R mod m), R = 2^WIDTH
//   in_one      Montgomery one (R mod m)
//   in_e        exponent
//   in_m        odd modulus, m > 1
//   result      x^e mod m in normal form, valid while done = 1
//   busy        high from the cycle after an accepted start until DONE
//   done        level, high in DONE until the next accepted start
//   mul_start   one-cycle pulse to the multiplier
//   mul_a/b/m   multiplier operands (registered)
//   mul_result  multiplier product; only bits [WIDTH-1:0] are used
//   mul_done    multiplier done level
//   state_dbg   current FSM state, for debug and checkers
//
// Multiplier handshake: mul_start is high for exactly the one cycle spent in
// SQR, MUL or OUT, with mul_a/mul_b/mul_m already stable in that cycle. The
// multiplier drops mul_done on the edge that samples mul_start, which is the
// same edge that enters the matching *_W state, so a stale done level from the
// previous product is never seen inside *_W. A *_W state leaves on the first
// edge where mul_done = 1; mul_done is ignored in every other state. Operands
// stay unchanged until that *_W state exits.
module mont_exp #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_one,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH+1:0]     mul_result,
  input  logic                 mul_done,
  output logic [3:0]           state_dbg
);

  localparam int IW = $clog2(EXP_WIDTH);

  localparam logic [IW-1:0]    IDX_TOP   = IW'(EXP_WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ZERO  = '0;
  localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
  localparam logic [WIDTH-1:0] ONE_PLAIN = WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SCAN  = 4'd1,
    SQR   = 4'd2,
    SQR_W = 4'd3,
    MUL   = 4'd4,
    MUL_W = 4'd5,
    NEXT  = 4'd6,
    OUT   = 4'd7,
    OUT_W = 4'd8,
    DONE  = 4'd9
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     one_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IW-1:0]        idx_q;
  logic [WIDTH-1:0]     acc_q;

  logic [WIDTH-1:0]     prod;
  logic                 bit_set;
  logic                 idx_last;
  logic                 unused_hi;

  // Bits above WIDTH carry the multiplier's unreduced headroom; not needed.
  assign prod      = mul_result[WIDTH-1:0];
  assign unused_hi = ^mul_result[WIDTH+1:WIDTH];

  assign bit_set   = e_q[idx_q];
  assign idx_last  = (idx_q == IDX_ZERO);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= IDLE;
      x_q       <= '0;
      one_q     <= '0;
      e_q       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
    end else begin
      // mul_start is a pulse: only the transitions into SQR/MUL/OUT raise it.
      mul_start <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_q   <= in_x;
            one_q <= in_one;
            e_q   <= in_e;
            mul_m <= in_m;
            idx_q <= IDX_TOP;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= SCAN;
          end
        end

        // Skip leading zero bits, one per cycle. The first set bit loads
        // A with x~ (the implicit "1 * x~" of square-and-multiply).
        SCAN: begin
          if (bit_set) begin
            acc_q     <= x_q;
            mul_a     <= x_q;
            mul_start <= 1'b1;
            if (idx_last) begin
              mul_b <= ONE_PLAIN;
              state <= OUT;
            end else begin
              mul_b <= x_q;
              idx_q <= idx_q - IDX_ONE;
              state <= SQR;
            end
          end else if (idx_last) begin
            // e == 0: the answer is the Montgomery one, converted out.
            acc_q     <= one_q;
            mul_a     <= one_q;
            mul_b     <= ONE_PLAIN;
            mul_start <= 1'b1;
            state     <= OUT;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end

        SQR: state <= SQR_W;

        // idx already points at the bit this square belongs to.
        SQR_W: begin
          if (mul_done) begin
            acc_q <= prod;
            if (bit_set) begin
              mul_a     <= prod;
              mul_b     <= x_q;
              mul_start <= 1'b1;
              state     <= MUL;
            end else begin
              state <= NEXT;
            end
          end
        end

        MUL: state <= MUL_W;

        MUL_W: begin
          if (mul_done) begin
            acc_q <= prod;
            state <= NEXT;
          end
        end

        NEXT: begin
          mul_a     <= acc_q;
          mul_start <= 1'b1;
          if (idx_last) begin
            mul_b <= ONE_PLAIN;
            state <= OUT;
          end else begin
            mul_b <= acc_q;
            idx_q <= idx_q - IDX_ONE;
            state <= SQR;
          end
        end

        // Multiplying by plain 1 strips the R factor (leaves Montgomery form).
        OUT: state <= OUT_W;

        OUT_W: begin
          if (mul_done) begin
            result <= prod;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mont_exp.md
# mont_exp

Modular-exponentiation controller for the RSA datapath. It computes `x^e mod m` by left-to-right square-and-multiply. It issues every multiplication to one external Montgomery multiplier through a start/done handshake, and consumes the multiplier's 514-bit result. It sits directly upstream of the multiplier, owns its operand buses, and is the block the top-level command interface starts for an encrypt/decrypt.

## Interface
Parameters:
- `WIDTH`, 512, operand/modulus width in bits.
- `EXP_WIDTH`, 512, exponent width in bits. Bit-index counter is `$clog2(EXP_WIDTH)` bits.

Ports:
- `clk`  in  1  — single clock; everything is on the rising edge.
- `resetn`  in  1  — asynchronous, active-high (1 = reset), despite the name.
- `start`  in  1  — one-cycle request. Honoured only in IDLE or DONE.
- `in_x`  in  WIDTH  — base, already in Montgomery form (x·R mod m), < m.
- `in_one`  in  WIDTH  — R mod m (Montgomery one), R = 2^WIDTH.
- `in_e`  in  EXP_WIDTH  — exponent.
- `in_m`  in  WIDTH  — odd modulus, m > 1.
- `result`  out  WIDTH  — x^e mod m in normal (non-Montgomery) form.
- `busy`  out  1  — high from the cycle after an accepted start until DONE.
- `done`  out  1  — level; high in DONE until the next accepted start.
- `mul_start`  out  1  — one-cycle pulse to the multiplier.
- `mul_a`, `mul_b`, `mul_m`  out  WIDTH  — multiplier operands (registered).
- `mul_result`  in  WIDTH+2  — multiplier output. Only bits [WIDTH-1:0] are used.
- `mul_done`  in  1  — multiplier done level.

## Operation
- Reset values: all outputs are 0, state is IDLE, internal registers are 0.
- On an accepted `start`, latch `in_x`, `in_e`, `in_m` and `in_one`. Set idx = EXP_WIDTH-1 and go to SCAN.
- `start` while busy is ignored. Latched inputs do not change during an operation.
- Accumulator A is a WIDTH-bit register.
- States and transitions:
  - IDLE: wait for `start`.
  - SCAN: one bit per cycle.
    - If e[idx]=1: A <= x̃. If idx=0, go to OUT; otherwise idx <= idx-1 and go to SQR.
    - If e[idx]=0 and idx=0 (e==0): A <= in_one, go to OUT.
    - Otherwise idx <= idx-1 and stay in SCAN.
  - SQR: mul_a=mul_b=A, pulse `mul_start`, go to SQR_W.
  - SQR_W: on `mul_done`, A <= mul_result[WIDTH-1:0]. Go to MUL if e[idx]=1, else NEXT.
  - MUL: mul_a=A, mul_b=x̃, pulse `mul_start`, go to MUL_W.
  - MUL_W: on `mul_done`, A <= result bits, go to NEXT.
  - NEXT: if idx=0, go to OUT; else idx <= idx-1 and go to SQR.
  - OUT: mul_a=A, mul_b=1, pulse `mul_start`, go to OUT_W. This multiplies by 1 to leave the Montgomery domain.
  - OUT_W: on `mul_done`, `result` <= result bits, go to DONE.
  - DONE: `done`=1, `result` held. An accepted `start` restarts as from IDLE.
- `mul_m` = latched m whenever busy.
- `mul_done` is sampled only in the *_W states. It is ignored everywhere else, including a stale high level left from the previous product.
- Multiplication count for MSB index k: k squares, plus popcount(e)-1 multiplies, plus 1 output multiply. For e==0, only the output multiply is issued; the result is 1.

## Timing
- Operands are registered one cycle before `mul_start` and held stable until the matching *_W exits.
- The multiplier deasserts `mul_done` the cycle after `mul_start`. *_W states are entered exactly then, so a previous done level cannot be mistaken for completion.
- A *_W state exits on the edge where `mul_done`=1. The next `mul_start` comes at the earliest 2 cycles later, because SQR/MUL/OUT each take one cycle.
- Latency is (EXP_WIDTH-k) SCAN cycles + Σ(multiplier latency + 2) + 1 for DONE.
- `result` updates and `done` rises on the same edge, when OUT_W exits.
- Async `resetn` mid-operation:
  - Immediately: `mul_start`=0, `busy`=0, `done`=0, `result`=0, state IDLE.
  - A `mul_done` arriving afterwards is ignored.

## Test plan
- m=13, in_one=9, x̃=5 (x=2), e=5 -> exactly 4 `mul_start` pulses; `result`=6; `done` stays high until the next start.
- Same m/x̃, e=0 -> exactly 1 `mul_start` (OUT with mul_a=9, mul_b=1); `result`=1.
- e=1 -> SCAN runs the full length to idx 0, then 1 pulse; `result`=2.
- e=12 -> 5 pulses (3 SQR, 1 MUL, 1 OUT); `result`=1. The bench holds `mul_done` high between products, and the FSM must not advance early.
- Pulse `start` with e=5 mid-operation -> ignored; the result is still from the first operands. Assert `resetn` during SQR_W -> next cycle `busy`=0, `result`=0, no further `mul_start`. A new start then gives the correct result.
- Random 512-bit m (odd), x, e against a software model: 20 vectors, all match; the pulse count matches k + popcount(e).
